aes128_inv_key_sched: RTL and testbench



---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_key_step.sv | 15 +
 rtl/aes128_inv_key_sched.sv | 66 ++++++
 tb/tb_aes128_inv_key_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES helpers (S-box, RotWord, Rcon) and key-scheduler FSM encoding
package aes_pkg;
  localparam int NR = 10;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t FWD  = 2'd1;
  localparam state_t EMIT = 2'd2;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] v;
    sq = x;
    v  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      v  = gf_mul(v, sq);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction
  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 2; i <= 10; i++)
      if (4'(i) <= r) c = xtime(c);
    return (r >= 4'd1 && r <= 4'd10) ? {c, 24'h0} : 32'h0;
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule round, forward (dir=0) or inverse (dir=1)
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] k_in,
  input  logic [3:0]   rnd,
  input  logic         dir,
  output logic [127:0] k_out
);
  logic [31:0] a, b, c, d, t;
  assign {a, b, c, d} = k_in;
  assign t = sub_word(rot_word(dir ? (d ^ c) : d)) ^ rcon(rnd);
  assign k_out = dir ? {a ^ t, b ^ a, c ^ b, d ^ c}
                     : {a ^ t, a ^ t ^ b, a ^ t ^ b ^ c, a ^ t ^ b ^ c ^ d};
endmodule

// File: rtl/aes128_inv_key_sched.sv
// aes128_inv_key_sched: streams AES-128 round keys 10..0 over valid/ready (start/key_in/key_is_last in, busy/rk_* out)
module aes128_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_is_last,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last
);
  if (NR != 10) begin : g_nr_check
    $error("aes128_inv_key_sched: NR must be 10");
  end
  state_t       state_q, state_d;
  logic [127:0] k_q, k_d, k_step;
  logic [3:0]   rnd_q, rnd_d;
  logic         emit, xfer;
  assign emit = state_q == EMIT;
  assign xfer = emit && rk_ready;
  aes_key_step u_step (
    .k_in  (k_q),
    .rnd   (emit ? rnd_q : rnd_q + 4'd1),
    .dir   (emit),
    .k_out (k_step)
  );
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rnd_d   = rnd_q;
    if (state_q == IDLE && start) begin
      state_d = key_is_last ? EMIT : FWD;
      k_d     = key_in;
      rnd_d   = key_is_last ? 4'(NR) : 4'd0;
    end else if (state_q == FWD || (xfer && rnd_q != 4'd0)) begin
      k_d     = k_step;
      rnd_d   = emit ? rnd_q - 4'd1 : rnd_q + 4'd1;
      state_d = (!emit && rnd_q == 4'(NR - 1)) ? EMIT : state_q;
    end else if (xfer) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rnd_q   <= rnd_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign rk_valid = emit;
  assign rk_out   = emit ? k_q : '0;
  assign rk_round = emit ? rnd_q : '0;
  assign rk_last  = emit && rnd_q == 4'd0;
endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// tb_aes128_inv_key_sched: directed self-checking bench for the reverse AES-128 key streamer
module tb_aes128_inv_key_sched;
  logic         clk = 1'b0;
  logic         rst, start, key_is_last, rk_ready;
  logic [127:0] key_in;
  logic         busy, rk_valid, rk_last;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  int           errors = 0;
  int           checks = 0;
  logic [127:0] exp_tab [3][11];
  aes128_inv_key_sched dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key_in      (key_in),
    .key_is_last (key_is_last),
    .busy        (busy),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_out      (rk_out),
    .rk_round    (rk_round),
    .rk_last     (rk_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [127:0] k, input logic l);
    start = 1'b1;
    key_in = k;
    key_is_last = l;
    step();
    start = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_out"}, rk_out, 128'(0));
    chk({tag, "_round"}, 128'(rk_round), 128'(0));
    chk({tag, "_last"}, 128'(rk_last), 128'(0));
  endtask
  task automatic wait_valid(input string tag, input int lat);
    int n = 0;
    while (!rk_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(lat));
  endtask
  task automatic collect(input string tag, input int set, input bit bp, input int stall_at, input bit pulse);
    int r = 10;
    int guard = 0;
    bit stalled = 1'b0;
    while (r >= 0 && guard < 300) begin
      guard++;
      if (r == stall_at && !stalled) begin
        stalled = 1'b1;
        rk_ready = 1'b0;
        repeat (5) begin
          step();
          chk({tag, "_stall_out"}, rk_out, exp_tab[set][r]);
          chk({tag, "_stall_round"}, 128'(rk_round), 128'(r));
        end
      end
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start = pulse && (r == 6 || r == 0);
      key_in = 128'h0123456789abcdef_fedcba9876543210;
      key_is_last = 1'b1;
      chk({tag, "_valid"}, 128'(rk_valid), 128'(1));
      chk({tag, "_busy"}, 128'(busy), 128'(1));
      chk({tag, "_round"}, 128'(rk_round), 128'(r));
      chk({tag, "_key"}, rk_out, exp_tab[set][r]);
      chk({tag, "_last"}, 128'(rk_last), 128'(r == 0));
      if (rk_ready) r--;
      step();
      start = 1'b0;
    end
    chk({tag, "_all_transferred"}, 128'(r + 1), 128'(0));
    chk({tag, "_end_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_end_busy"}, 128'(busy), 128'(0));
    step();
    chk({tag, "_idle_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
    rk_ready = 1'b1;
  endtask
  initial begin
    exp_tab[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                   128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
                   128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                   128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                   128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    exp_tab[1] = '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
                   128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
                   128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
                   128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
                   128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
                   128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    exp_tab[2] = '{128'hffffffffffffffffffffffffffffffff, 128'he8e9e9e917161616e8e9e9e917161616,
                   128'hadaeae19bab8b80f525151e6454747f0, 128'h090e2277b3b69a78e1e7cb9ea4a08c6e,
                   128'he16abd3e52dc2746b33becd8179b60b6, 128'he5baf3ceb766d488045d385013c658e6,
                   128'h71d07db3c6b6a93bc2eb916bd12dc98d, 128'he90d208d2fbb89b6ed5018dd3c7dd150,
                   128'h96337366b988fad054d8e20d68a5335d, 128'h8bf03f233278c5f366a027fe0e0514a3,
                   128'hd60a3588e472f07b82d2d7858cd7c326};
    rst = 1'b1;
    start = 1'b0;
    key_in = '0;
    key_is_last = 1'b0;
    rk_ready = 1'b0;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;
    rk_ready = 1'b1;
    step();
    do_start(exp_tab[0][0], 1'b0);
    repeat (3) step();
    start = 1'b1;
    key_in = exp_tab[1][0];
    key_is_last = 1'b1;
    step();
    start = 1'b0;
    chk("fwd_start_busy", 128'(busy), 128'(1));
    chk("fwd_start_valid", 128'(rk_valid), 128'(0));
    wait_valid("fips_fwd", 6);
    collect("fips_fwd", 0, 1'b0, -1, 1'b1);
    do_start(exp_tab[0][10], 1'b1);
    wait_valid("fips_last", 0);
    collect("fips_last", 0, 1'b0, -1, 1'b0);
    do_start(exp_tab[0][0], 1'b0);
    wait_valid("fips_bp", 10);
    collect("fips_bp", 0, 1'b1, 4, 1'b0);
    do_start(exp_tab[0][0], 1'b0);
    repeat (5) step();
    chk("rst_fwd_busy_before", 128'(busy), 128'(1));
    rst = 1'b1;
    step();
    chk_reset("rst_fwd");
    rst = 1'b0;
    step();
    step();
    chk("rst_fwd_quiet", 128'(rk_valid), 128'(0));
    do_start(exp_tab[0][10], 1'b1);
    repeat (3) step();
    chk("rst_emit_round_before", 128'(rk_round), 128'(7));
    rst = 1'b1;
    rk_ready = 1'b0;
    step();
    chk_reset("rst_emit");
    rst = 1'b0;
    rk_ready = 1'b1;
    step();
    step();
    chk("rst_emit_quiet", 128'(rk_valid), 128'(0));
    do_start(exp_tab[0][0], 1'b0);
    wait_valid("after_rst", 10);
    collect("after_rst", 0, 1'b0, -1, 1'b0);
    do_start(exp_tab[1][0], 1'b0);
    wait_valid("zero_key", 10);
    collect("zero_key", 1, 1'b0, -1, 1'b1);
    do_start(exp_tab[2][0], 1'b0);
    wait_valid("ones_key", 10);
    collect("ones_key", 2, 1'b1, -1, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
